// File: rtl/register_write_scheduler_pkg.sv
// register_write_scheduler_pkg: shared register-write types, scope decode and scheduler states
package register_write_scheduler_pkg;
  typedef struct packed {
    logic [15:0] number;
    logic [15:0] value;
  } RegisterWrite_t;
  typedef enum logic [1:0] {
    SCOPE_RESERVED = 2'b00,
    SCOPE_GLOBAL   = 2'b01,
    SCOPE_VOICE    = 2'b10,
    SCOPE_VOICEOP  = 2'b11
  } RegScope_t;
  typedef enum logic {
    S_IDLE,
    S_WAIT_FRAME
  } sched_state_t;
  function automatic RegScope_t getRegScope(input logic [1:0] number_hi);
    return RegScope_t'(number_hi);
  endfunction
endpackage

// File: rtl/register_write_scheduler_sync.sv
// sync_fifo: single-clock FIFO with combinational head read and level counter
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Push,
  input  logic                   i_Pop,
  input  logic [WIDTH-1:0]       i_Data,
  output logic [WIDTH-1:0]       o_Data,
  output logic [$clog2(DEPTH):0] o_Level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic push, pop;
  always_comb begin
    push = i_Push && (level_q < (AW+1)'(DEPTH));
    pop = i_Pop && (level_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge i_Clock) if (push) mem[wr_ptr_q] <= i_Data;
  assign o_Data = mem[rd_ptr_q];
  assign o_Level = level_q;
endmodule

// File: rtl/register_write_scheduler.sv
// register_write_scheduler: FIFO-buffers host writes and issues them to the synth bus, holding global writes to the frame boundary
module register_write_scheduler
  import register_write_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_WriteValid,
  output logic                        o_WriteReady,
  input  logic [15:0]                 i_WriteNumber,
  input  logic [15:0]                 i_WriteValue,
  input  logic                        i_FrameStart,
  output logic                        o_RegisterWriteEnable,
  output logic [15:0]                 o_RegisterWriteNumber,
  output logic [15:0]                 o_RegisterWriteValue,
  output logic                        o_GlobalPending,
  output logic                        o_DroppedReserved,
  output logic [$clog2(FIFO_DEPTH):0] o_FifoLevel
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  sched_state_t state_q, state_d;
  RegisterWrite_t held_q, held_d, out_q, out_d, head;
  logic en_q, en_d, drop_q, drop_d, pop, push;
  logic [31:0] fifo_data;
  RegScope_t scope;
  assign o_WriteReady = o_FifoLevel < LW'(FIFO_DEPTH);
  assign push = i_WriteValid && o_WriteReady;
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Push(push),
    .i_Pop(pop),
    .i_Data({i_WriteNumber, i_WriteValue}),
    .o_Data(fifo_data),
    .o_Level(o_FifoLevel)
  );
  assign head = RegisterWrite_t'(fifo_data);
  assign scope = getRegScope(head.number[15:14]);
  always_comb begin
    state_d = state_q;
    held_d = held_q;
    out_d = out_q;
    en_d = 1'b0;
    drop_d = 1'b0;
    pop = 1'b0;
    if (state_q == S_WAIT_FRAME) begin
      if (i_FrameStart) begin
        en_d = 1'b1;
        out_d = held_q;
        state_d = S_IDLE;
      end
    end else if (o_FifoLevel != '0) begin
      pop = 1'b1;
      if (scope == SCOPE_RESERVED) drop_d = 1'b1;
      else if (scope == SCOPE_GLOBAL && !i_FrameStart) begin
        held_d = head;
        state_d = S_WAIT_FRAME;
      end else begin
        en_d = 1'b1;
        out_d = head;
      end
    end
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      held_q <= '0;
      out_q <= '0;
      en_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q <= held_d;
      out_q <= out_d;
      en_q <= en_d;
      drop_q <= drop_d;
    end
  end
  assign o_RegisterWriteEnable = en_q;
  assign o_RegisterWriteNumber = out_q.number;
  assign o_RegisterWriteValue = out_q.value;
  assign o_GlobalPending = (state_q == S_WAIT_FRAME);
  assign o_DroppedReserved = drop_q;
endmodule

// File: tb/tb_register_write_scheduler.sv
// tb_register_write_scheduler: directed steps with a scoreboard of expected bus writes
module tb_register_write_scheduler;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, frame = 1'b0;
  logic [15:0] num = '0, val = '0;
  logic ready, en, pending, drop;
  logic [15:0] onum, oval;
  logic [4:0] level;
  int errors = 0, checks = 0, strobes = 0, drops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  register_write_scheduler #(.FIFO_DEPTH(16)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_WriteValid(valid), .o_WriteReady(ready),
    .i_WriteNumber(num), .i_WriteValue(val), .i_FrameStart(frame),
    .o_RegisterWriteEnable(en), .o_RegisterWriteNumber(onum), .o_RegisterWriteValue(oval),
    .o_GlobalPending(pending), .o_DroppedReserved(drop), .o_FifoLevel(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (drop) drops++;
    if (en) begin
      strobes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: got %h/%h expected no strobe", onum, oval);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({onum, oval} === e) else begin
          errors++;
          $error("FAIL sb_order: got %h/%h expected %h/%h", onum, oval, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] n, input logic [15:0] v, input bit track);
    valid = 1'b1;
    num = n;
    val = v;
    for (int i = 0; i < 40 && !ready; i++) tick();
    chk("push_ready", 32'(ready), 1);
    if (track && n[15:14] != 2'b00) exp_q.push_back({n, v});
    tick();
    valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_en", 32'(en), 0);
    chk("rst_num", 32'(onum), 0);
    chk("rst_val", 32'(oval), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_level", 32'(level), 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 1);
    // single voice-op write: strobe in the cycle after the pop edge
    push(16'hC000, 16'h1234, 1);
    chk("t1_level_acc", 32'(level), 1);
    chk("t1_no_early", 32'(en), 0);
    tick();
    chk("t1_strobe", 32'(en), 1);
    chk("t1_num", 32'(onum), 32'h0000C000);
    chk("t1_level0", 32'(level), 0);
    tick();
    chk("t1_single", 32'(en), 0);
    chk("t1_hold", {onum, oval}, 32'hC0001234);
    // four back-to-back voice-op writes
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      num = 16'hC010 + 16'(i);
      val = 16'h0100 + 16'(i);
      exp_q.push_back({num, val});
      tick();
      if (i > 0) chk("t2_consec", 32'(en), 1);
      chk("t2_pending", 32'(pending), 0);
    end
    valid = 1'b0;
    tick();
    chk("t2_last", 32'(en), 1);
    chk("t2_last_num", 32'(onum), 32'h0000C013);
    tick();
    chk("t2_done", 32'(en), 0);
    // global write held until the frame pulse
    push(16'h4000, 16'h0001, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_pending", 32'(pending), 1);
      chk("t3_no_strobe", 32'(en), 0);
      tick();
    end
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("t3_strobe", 32'(en), 1);
    chk("t3_num", {onum, oval}, 32'h40000001);
    chk("t3_released", 32'(pending), 0);
    tick();
    chk("t3_single", 32'(en), 0);
    // later writes queue behind a held global write
    push(16'h4000, 16'h0002, 1);
    push(16'hC001, 16'h00AA, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_pending", 32'(pending), 1);
    chk("t4_level", 32'(level), 1);
    chk("t4_no_strobe", 32'(en), 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("t4_first", {32'(en), 32'(onum)} == {32'd1, 32'h4000}, 1);
    tick();
    chk("t4_second", {32'(en), 32'(onum)} == {32'd1, 32'hC001}, 1);
    tick();
    chk("t4_done", 32'(en), 0);
    // fill the FIFO behind a held global write
    push(16'h4000, 16'h0003, 1);
    tick();
    chk("t5_held", 32'(pending), 1);
    push(16'h4001, 16'h0004, 1);
    for (int i = 0; i < 15; i++) push(16'hC100 + 16'(i), 16'h0200 + 16'(i), 1);
    chk("t5_full_level", 32'(level), 16);
    chk("t5_not_ready", 32'(ready), 0);
    valid = 1'b1;
    num = 16'hC1FF;
    val = 16'h0BEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_blocked_level", 32'(level), 16);
      chk("t5_blocked_ready", 32'(ready), 0);
    end
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("t5_frame_strobe", 32'(en), 1);
    chk("t5_no_pushthru", 32'(level), 16);
    tick();
    chk("t5_pop_level", 32'(level), 15);
    chk("t5_ready_again", 32'(ready), 1);
    exp_q.push_back({num, val});
    tick();
    valid = 1'b0;
    chk("t5_accepted", 32'(level), 16);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t5_drained_level", 32'(level), 0);
    chk("t5_drained_sb", 32'(exp_q.size()), 0);
    // reserved write dropped, then reset with a global write held
    push(16'h0000, 16'hFFFF, 1);
    tick();
    chk("t6_drop", 32'(drop), 1);
    chk("t6_drop_nostrobe", 32'(en), 0);
    tick();
    chk("t6_drop_once", 32'(drop), 0);
    push(16'h4000, 16'h0005, 0);
    tick();
    chk("t6_held", 32'(pending), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_level", 32'(level), 0);
    chk("t6_pending", 32'(pending), 0);
    chk("t6_ready", 32'(ready), 1);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_lost", 32'(en), 0);
      tick();
    end
    chk("strobe_total", 32'(strobes), 26);
    chk("drop_total", 32'(drops), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
